external_stall_ctrl: RTL

//  Requester side of the hazard unit's ExternalStall input: converts halt/resume requests into a

---
 rtl/external_stall_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/external_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : external_stall_ctrl
// Brief    : Converts halt/resume requests into a registered ExternalStall
//            level for the hazard unit. Halt waits for IFU/LSU/divide/trap
//            activity to drain, bounded by DRAIN_TIMEOUT. Define HALT_STEP_EN
//            to add the StepReq single-step feature.
// Revision : 1.0 - initial release
// ============================================================================
module external_stall_ctrl #(
    parameter int DRAIN_TIMEOUT = 64,
    parameter int MIN_HALT      = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             HaltReq,
    input  logic             ResumeReq,
    input  logic             LSUStallM,
    input  logic             IFUStallF,
    input  logic             DivBusyE,
    input  logic             FDivBusyE,
    input  logic             TrapM,
`ifdef HALT_STEP_EN
    input  logic             StepReq,
`endif
    output logic             ExternalStall,
    output logic             Halted,
    output logic             HaltTimeout,
    output logic [CNT_W-1:0] HaltCycles
);

    localparam int c_drainCntW = $clog2(DRAIN_TIMEOUT + 1);
    localparam int c_minCntW   = $clog2(MIN_HALT + 1);
    localparam logic [c_drainCntW-1:0] c_drainLast = c_drainCntW'(DRAIN_TIMEOUT - 1);
    localparam logic [c_minCntW-1:0]   c_minHalt   = c_minCntW'(MIN_HALT);
    localparam logic [c_minCntW-1:0]   c_minOne    = c_minCntW'(1);

`ifdef HALT_STEP_EN
    typedef enum logic [2:0] {
        S_RUN    = 3'd0,
        S_DRAIN  = 3'd1,
        S_HALT   = 3'd2,
        S_RESUME = 3'd3,
        S_STEP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALT   = 2'd2,
        S_RESUME = 2'd3
    } state_t;
`endif

    state_t                 r_state;
    state_t                 w_nextState;
    logic [c_drainCntW-1:0] r_drainCnt;
    logic [c_minCntW-1:0]   r_minCnt;
    logic                   r_externalStall;
    logic                   r_halted;
    logic                   r_haltTimeout;
    logic [CNT_W-1:0]       r_haltCycles;

    logic w_quiet;
    logic w_minMet;
    logic w_timeoutHalt;
    logic w_inHaltNow;
    logic w_inHaltNext;
    logic w_haltFromDrain;

    assign w_quiet  = ~(LSUStallM | IFUStallF | DivBusyE | FDivBusyE | TrapM);
    assign w_minMet = (r_minCnt >= c_minHalt);

`ifdef HALT_STEP_EN
    logic r_stepPrev;
    logic w_stepRise;
    assign w_stepRise   = StepReq & ~r_stepPrev;
    assign w_inHaltNow  = (r_state == S_HALT) || (r_state == S_STEP);
    assign w_inHaltNext = (w_nextState == S_HALT) || (w_nextState == S_STEP);
`else
    assign w_inHaltNow  = (r_state == S_HALT);
    assign w_inHaltNext = (w_nextState == S_HALT);
`endif

    assign w_haltFromDrain = (r_state == S_DRAIN) && (w_nextState == S_HALT);

    // Abort has priority in DRAIN so a withdrawn request never stalls the pipe
    always_comb begin
        w_nextState   = r_state;
        w_timeoutHalt = 1'b0;
        case (r_state)
            S_RUN: begin
                if (HaltReq) w_nextState = S_DRAIN;
            end
            S_DRAIN: begin
                if (!HaltReq) begin
                    w_nextState = S_RUN;
                end else if (w_quiet) begin
                    w_nextState = S_HALT;
                end else if (r_drainCnt == c_drainLast) begin
                    w_nextState   = S_HALT;
                    w_timeoutHalt = 1'b1;
                end
            end
            S_HALT: begin
                if (ResumeReq && w_minMet) begin
                    w_nextState = S_RESUME;
`ifdef HALT_STEP_EN
                end else if (w_stepRise && w_minMet) begin
                    w_nextState = S_STEP;
`endif
                end
            end
            S_RESUME: begin
                w_nextState = S_RUN;
            end
`ifdef HALT_STEP_EN
            S_STEP: begin
                w_nextState = S_HALT;
            end
`endif
            default: begin
                w_nextState = S_RUN;
            end
        endcase
    end

    // Outputs are registered from the next state so they change with the state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state         <= S_RUN;
            r_drainCnt      <= '0;
            r_minCnt        <= '0;
            r_externalStall <= 1'b0;
            r_halted        <= 1'b0;
            r_haltTimeout   <= 1'b0;
            r_haltCycles    <= '0;
        end else begin
            r_state         <= w_nextState;
            r_externalStall <= (w_nextState == S_HALT);
            r_halted        <= w_inHaltNext;

            if ((r_state == S_DRAIN) && (w_nextState == S_DRAIN)) begin
                r_drainCnt <= r_drainCnt + 1'b1;
            end else begin
                r_drainCnt <= '0;
            end

            if (w_nextState == S_HALT) begin
                if (r_state != S_HALT) begin
                    r_minCnt <= c_minOne;
                end else if (!w_minMet) begin
                    r_minCnt <= r_minCnt + 1'b1;
                end
            end else begin
                r_minCnt <= '0;
            end

            if (w_haltFromDrain) begin
                r_haltCycles  <= CNT_W'(1);
                r_haltTimeout <= w_timeoutHalt;
            end else if (w_inHaltNow && w_inHaltNext && (r_haltCycles != '1)) begin
                r_haltCycles <= r_haltCycles + 1'b1;
            end
        end
    end

`ifdef HALT_STEP_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stepPrev <= 1'b0;
        end else begin
            r_stepPrev <= StepReq;
        end
    end
`endif

    assign ExternalStall = r_externalStall;
    assign Halted        = r_halted;
    assign HaltTimeout   = r_haltTimeout;
    assign HaltCycles    = r_haltCycles;

endmodule
`default_nettype wire
